// File: rtl/game_pkg.sv
// game_pkg: shared types and helpers for the memory game controller.
//   state_t       - controller FSM encoding (also exported on the state port)
//   KEY_*         - bit positions inside the one-hot-ish keys pulse vector
//   sat_inc16()   - 16-bit increment that sticks at all-ones
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PICK1   = 3'd1,
        ST_PICK2   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_SHOW    = 3'd4,
        ST_CLEAR   = 3'd5,
        ST_WIN     = 3'd6
    } state_t;

    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_UP    = 3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cursor_nav.sv
// cursor_nav: row/column cursor over a COLS x ROWS board.
//   clock, reset_n - system clock, async active-low reset
//   en             - allow key moves this cycle
//   clr            - return cursor to (0,0); wins over en
//   keys           - move pulses, priority up > down > left > right
//   idx            - linear index row*COLS+col
// Moves wrap within the current row (left/right) or column (up/down).
module cursor_nav
    import game_pkg::*;
#(
    parameter int COLS  = 6,
    parameter int ROWS  = 6,
    parameter int IDX_W = $clog2(COLS*ROWS)
)(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [3:0]       keys,
    output logic [IDX_W-1:0] idx
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS-1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS-1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (keys[KEY_UP])
                row <= (row == '0) ? ROW_MAX : row - 1'b1;
            else if (keys[KEY_DOWN])
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            else if (keys[KEY_LEFT])
                col <= (col == '0) ? COL_MAX : col - 1'b1;
            else if (keys[KEY_RIGHT])
                col <= (col == COL_MAX) ? '0 : col + 1'b1;
        end
    end

    assign idx = IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);

endmodule

// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: card-matching game controller.
//   clock, reset_n   - system clock, async active-low reset
//   start, select    - synchronised one-cycle pulses
//   keys             - move pulses [0] right [1] left [2] down [3] up
//   card_sym         - symbol of the card at card_addr (combinational source)
//   card_addr        - board lookup address (= cursor_idx)
//   cursor_idx       - cursor position row*COLS+col
//   sym1, sym2       - first/second picked symbols
//   revealed,matched - face-up and matched masks
//   pairs, moves     - pairs found this board, pair attempts (saturating)
//   level            - current level from 0
//   state            - FSM state (game_pkg encoding)
//   board_done, win  - board-clear pulse, win flag
//
// state   | meaning
// IDLE    | board reset, wait for start
// PICK1   | navigate, pick first card
// PICK2   | navigate, pick a different second card
// COMPARE | one cycle: compare sym1/sym2
// SHOW    | mismatch held face-up until timer reaches 0
// CLEAR   | one cycle: board finished, advance level or win
// WIN     | game won, wait for start
module memory_game_ctrl
    import game_pkg::*;
#(
    parameter int COLS        = 6,
    parameter int ROWS        = 6,
    parameter int SYM_W       = 5,
    parameter int SHOW_CYCLES = 50_000_000,
    parameter int MAX_LEVEL   = 3,
    localparam int N      = COLS*ROWS,
    localparam int IDX_W  = $clog2(N),
    localparam int PAIR_W = $clog2(N/2+1),
    localparam int LVL_W  = $clog2(MAX_LEVEL+1)
)(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        keys,
    input  logic              select,
    input  logic [SYM_W-1:0]  card_sym,
    output logic [IDX_W-1:0]  card_addr,
    output logic [IDX_W-1:0]  cursor_idx,
    output logic [SYM_W-1:0]  sym1,
    output logic [SYM_W-1:0]  sym2,
    output logic [N-1:0]      revealed,
    output logic [N-1:0]      matched,
    output logic [PAIR_W-1:0] pairs,
    output logic [15:0]       moves,
    output logic [LVL_W-1:0]  level,
    output logic [2:0]        state,
    output logic              board_done,
    output logic              win
);

    localparam int TMR_W = $clog2(SHOW_CYCLES);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cursor, first_idx, second_idx;
    logic [SYM_W-1:0]   sym1_q, sym2_q;
    logic [N-1:0]       revealed_q, matched_q;
    logic [PAIR_W-1:0]  pairs_q, pairs_nxt;
    logic [15:0]        moves_q;
    logic [LVL_W-1:0]   level_q;
    logic [TMR_W-1:0]   timer_q;
    logic               board_done_q, win_q;
    logic               nav_en, nav_clr;
    logic               sel1_ok, sel2_ok, sym_eq, timer_tc, last_level;

    cursor_nav #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .IDX_W (IDX_W)
    ) u_nav (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (nav_en),
        .clr     (nav_clr),
        .keys    (keys),
        .idx     (cursor)
    );

    assign pairs_nxt  = pairs_q + 1'b1;
    assign sym_eq     = (sym1_q == sym2_q);
    assign timer_tc   = (timer_q == '0);
    assign last_level = (level_q == LVL_W'(MAX_LEVEL-1));
    // Matched cards can never be picked; the second pick must differ from the first.
    assign sel1_ok    = select && !matched_q[cursor];
    assign sel2_ok    = sel1_ok && (cursor != first_idx);

    always_comb begin
        state_d = state_q;
        nav_en  = 1'b0;
        nav_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                nav_clr = 1'b1;
                if (start) state_d = ST_PICK1;
            end
            ST_PICK1: begin
                nav_en = 1'b1;
                if (sel1_ok) state_d = ST_PICK2;
            end
            ST_PICK2: begin
                nav_en = 1'b1;
                if (sel2_ok) state_d = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (!sym_eq)
                    state_d = ST_SHOW;
                else if (pairs_nxt == PAIR_W'(N/2))
                    state_d = ST_CLEAR;
                else
                    state_d = ST_PICK1;
            end
            ST_SHOW: begin
                if (timer_tc) state_d = ST_PICK1;
            end
            ST_CLEAR: begin
                state_d = last_level ? ST_WIN : ST_IDLE;
            end
            ST_WIN: begin
                if (start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first_idx    <= '0;
            second_idx   <= '0;
            sym1_q       <= '0;
            sym2_q       <= '0;
            revealed_q   <= '0;
            matched_q    <= '0;
            pairs_q      <= '0;
            moves_q      <= '0;
            level_q      <= '0;
            timer_q      <= '0;
            board_done_q <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            // Flags track the state being entered so they line up with state.
            board_done_q <= (state_d == ST_CLEAR);
            win_q        <= (state_d == ST_WIN);
            case (state_q)
                ST_IDLE: begin
                    revealed_q <= '0;
                    matched_q  <= '0;
                    pairs_q    <= '0;
                    moves_q    <= '0;
                    sym1_q     <= '0;
                    sym2_q     <= '0;
                end
                ST_PICK1: begin
                    if (sel1_ok) begin
                        first_idx          <= cursor;
                        sym1_q             <= card_sym;
                        revealed_q[cursor] <= 1'b1;
                    end
                end
                ST_PICK2: begin
                    if (sel2_ok) begin
                        second_idx         <= cursor;
                        sym2_q             <= card_sym;
                        revealed_q[cursor] <= 1'b1;
                        moves_q            <= sat_inc16(moves_q);
                    end
                end
                ST_COMPARE: begin
                    if (sym_eq) begin
                        matched_q[first_idx]  <= 1'b1;
                        matched_q[second_idx] <= 1'b1;
                        pairs_q               <= pairs_nxt;
                    end else begin
                        timer_q <= TMR_W'(SHOW_CYCLES-1);
                    end
                end
                ST_SHOW: begin
                    if (timer_tc) begin
                        revealed_q[first_idx]  <= 1'b0;
                        revealed_q[second_idx] <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (!last_level) level_q <= level_q + 1'b1;
                end
                ST_WIN: begin
                    if (start) level_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign card_addr  = cursor;
    assign cursor_idx = cursor;
    assign sym1       = sym1_q;
    assign sym2       = sym2_q;
    assign revealed   = revealed_q;
    assign matched    = matched_q;
    assign pairs      = pairs_q;
    assign moves      = moves_q;
    assign level      = level_q;
    assign state      = state_q;
    assign board_done = board_done_q;
    assign win        = win_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Testbench for memory_game_ctrl on a 2x2 board {3,7,3,7}, SHOW_CYCLES=4,
// MAX_LEVEL=2. Stimulus pushes cycle-tagged expectations into a queue; the
// monitor compares them on the falling edge of the tagged cycle.
module tb_memory_game_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        select = 1'b0;
    logic [3:0]  keys = 4'd0;
    logic [4:0]  card_sym;
    logic [1:0]  card_addr, cursor_idx;
    logic [4:0]  sym1, sym2;
    logic [3:0]  revealed, matched;
    logic [1:0]  pairs;
    logic [15:0] moves;
    logic [1:0]  level;
    logic [2:0]  state;
    logic        board_done, win;

    logic [4:0] board [4] = '{5'd3, 5'd7, 5'd3, 5'd7};
    assign card_sym = board[card_addr];

    memory_game_ctrl #(
        .COLS(2), .ROWS(2), .SYM_W(5), .SHOW_CYCLES(4), .MAX_LEVEL(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .keys(keys),
        .select(select), .card_sym(card_sym), .card_addr(card_addr),
        .cursor_idx(cursor_idx), .sym1(sym1), .sym2(sym2),
        .revealed(revealed), .matched(matched), .pairs(pairs),
        .moves(moves), .level(level), .state(state),
        .board_done(board_done), .win(win)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum int {F_STATE, F_CURSOR, F_REV, F_MAT, F_PAIRS, F_MOVES,
                      F_LEVEL, F_WIN, F_DONE, F_SYM1, F_SYM2} fld_t;
    typedef struct {
        int    cyc;
        fld_t  fld;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int done_count = 0;

    function automatic int actual(fld_t f);
        case (f)
            F_STATE:  return int'(state);
            F_CURSOR: return int'(cursor_idx);
            F_REV:    return int'(revealed);
            F_MAT:    return int'(matched);
            F_PAIRS:  return int'(pairs);
            F_MOVES:  return int'(moves);
            F_LEVEL:  return int'(level);
            F_WIN:    return int'(win);
            F_DONE:   return int'(board_done);
            F_SYM1:   return int'(sym1);
            F_SYM2:   return int'(sym2);
            default:  return -1;
        endcase
    endfunction

    task automatic push_exp(string name, fld_t f, int val, int dly);
        exp_t e;
        e.cyc  = cyc + dly;
        e.fld  = f;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due this cycle.
    always @(negedge clock) begin
        if (board_done) done_count++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                int a;
                a = actual(sb[i].fld);
                n_cmp++;
                if (sb[i].cyc != cyc || a != sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s: got %0d, expected %0d (due cycle %0d, checked %0d)",
                             sb[i].name, a, sb[i].val, sb[i].cyc, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic drive(input logic s, input logic [3:0] k, input logic sel);
        start  = s;
        keys   = k;
        select = sel;
        @(posedge clock);
        #1;
        start  = 1'b0;
        keys   = 4'd0;
        select = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Power-on reset
        tick(3);
        reset_n = 1'b1;
        push_exp("rst_state", F_STATE, 0, 0);
        push_exp("rst_cursor", F_CURSOR, 0, 0);
        push_exp("rst_rev", F_REV, 0, 0);
        push_exp("rst_win", F_WIN, 0, 0);
        tick(1);

        // Mismatch: idx0 (3) vs idx1 (7)
        drive(1, 4'b0000, 0); push_exp("mm_pick1", F_STATE, 1, 0);
        drive(0, 4'b0000, 1); push_exp("mm_pick2", F_STATE, 2, 0);
                              push_exp("mm_rev1", F_REV, 4'b0001, 0);
                              push_exp("mm_sym1", F_SYM1, 3, 0);
        drive(0, 4'b0001, 0); push_exp("mm_right", F_CURSOR, 1, 0);
        drive(0, 4'b0000, 1); push_exp("mm_cmp", F_STATE, 3, 0);
                              push_exp("mm_rev2", F_REV, 4'b0011, 0);
                              push_exp("mm_moves", F_MOVES, 1, 0);
                              push_exp("mm_sym2", F_SYM2, 7, 0);
        push_exp("mm_show_first", F_STATE, 4, 1);
        push_exp("mm_show_last", F_STATE, 4, 4);
        push_exp("mm_rev_held", F_REV, 4'b0011, 4);
        push_exp("mm_back_pick1", F_STATE, 1, 5);
        push_exp("mm_rev_cleared", F_REV, 0, 5);
        tick(5);

        // Second mismatch, reset while in SHOW
        drive(0, 4'b0000, 1); push_exp("rs_pick2", F_STATE, 2, 0);
                              push_exp("rs_rev", F_REV, 4'b0010, 0);
        drive(0, 4'b0010, 0); push_exp("rs_left", F_CURSOR, 0, 0);
        drive(0, 4'b0000, 1); push_exp("rs_moves", F_MOVES, 2, 0);
        push_exp("rs_show", F_STATE, 4, 1);
        tick(2);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        push_exp("rs_state", F_STATE, 0, 0);
        push_exp("rs_rev0", F_REV, 0, 0);
        push_exp("rs_mat0", F_MAT, 0, 0);
        push_exp("rs_level0", F_LEVEL, 0, 0);
        push_exp("rs_pairs0", F_PAIRS, 0, 0);
        push_exp("rs_moves0", F_MOVES, 0, 0);
        push_exp("rs_sym1_0", F_SYM1, 0, 0);

        // keys/select ignored in IDLE
        drive(0, 4'b0001, 1); push_exp("idle_ign_state", F_STATE, 0, 0);
                              push_exp("idle_ign_cursor", F_CURSOR, 0, 0);

        // Match: idx0 and idx2 (both 3)
        drive(1, 4'b0000, 0); push_exp("m_pick1", F_STATE, 1, 0);
        drive(0, 4'b0000, 1); push_exp("m_rev1", F_REV, 4'b0001, 0);
        drive(0, 4'b0100, 0); push_exp("m_down", F_CURSOR, 2, 0);
        drive(0, 4'b0000, 1); push_exp("m_cmp", F_STATE, 3, 0);
                              push_exp("m_rev2", F_REV, 4'b0101, 0);
        push_exp("m_state", F_STATE, 1, 1);
        push_exp("m_matched", F_MAT, 4'b0101, 1);
        push_exp("m_pairs", F_PAIRS, 1, 1);
        tick(1);
        drive(0, 4'b0000, 1); push_exp("m_sel2_ign", F_STATE, 1, 0);
        drive(0, 4'b1000, 0); push_exp("m_up", F_CURSOR, 0, 0);
        drive(0, 4'b0000, 1); push_exp("m_sel0_ign", F_STATE, 1, 0);
                              push_exp("m_sel0_rev", F_REV, 4'b0101, 0);

        // Cursor wrap and priority
        drive(0, 4'b0001, 0); push_exp("w_r1", F_CURSOR, 1, 0);
        drive(0, 4'b0001, 0); push_exp("w_r2", F_CURSOR, 0, 0);
        drive(0, 4'b1000, 0); push_exp("w_up", F_CURSOR, 2, 0);
        drive(0, 4'b1000, 0); push_exp("w_up2", F_CURSOR, 0, 0);
        drive(0, 4'b1001, 0); push_exp("w_up_wins", F_CURSOR, 2, 0);
        drive(0, 4'b0110, 0); push_exp("w_down_wins", F_CURSOR, 0, 0);

        // Same card twice in PICK2, then finish board 0
        drive(0, 4'b0001, 0); push_exp("s_right", F_CURSOR, 1, 0);
        drive(0, 4'b0000, 1); push_exp("s_pick2", F_STATE, 2, 0);
                              push_exp("s_sym1", F_SYM1, 7, 0);
        drive(0, 4'b0000, 1); push_exp("s_same_state", F_STATE, 2, 0);
                              push_exp("s_same_moves", F_MOVES, 1, 0);
                              push_exp("s_same_rev", F_REV, 4'b0111, 0);
        drive(0, 4'b0100, 0); push_exp("s_down", F_CURSOR, 3, 0);
        drive(0, 4'b0000, 1); push_exp("s_moves2", F_MOVES, 2, 0);
                              push_exp("s_rev_all", F_REV, 4'b1111, 0);
        push_exp("b0_clear", F_STATE, 5, 1);
        push_exp("b0_done", F_DONE, 1, 1);
        push_exp("b0_mat", F_MAT, 4'b1111, 1);
        push_exp("b0_pairs", F_PAIRS, 2, 1);
        push_exp("b0_idle", F_STATE, 0, 2);
        push_exp("b0_level", F_LEVEL, 1, 2);
        push_exp("b0_done_low", F_DONE, 0, 2);
        push_exp("b0_rev_clr", F_REV, 0, 3);
        push_exp("b0_mat_clr", F_MAT, 0, 3);
        push_exp("b0_moves_clr", F_MOVES, 0, 3);
        push_exp("b0_cursor_clr", F_CURSOR, 0, 3);
        tick(3);

        // Board 1 (last level) -> WIN
        drive(1, 4'b0000, 0); push_exp("b1_pick1", F_STATE, 1, 0);
                              push_exp("b1_level", F_LEVEL, 1, 0);
        drive(0, 4'b0000, 1); push_exp("b1_sym1", F_SYM1, 3, 0);
        drive(0, 4'b0100, 0); push_exp("b1_down", F_CURSOR, 2, 0);
        drive(0, 4'b0000, 1); push_exp("b1_cmp", F_STATE, 3, 0);
        push_exp("b1_pairs1", F_PAIRS, 1, 1);
        tick(1);
        drive(0, 4'b0001, 0); push_exp("b1_right", F_CURSOR, 3, 0);
        drive(0, 4'b0000, 1); push_exp("b1_rev", F_REV, 4'b1101, 0);
        drive(0, 4'b1000, 0); push_exp("b1_up", F_CURSOR, 1, 0);
        drive(0, 4'b0000, 1); push_exp("b1_moves", F_MOVES, 2, 0);
        push_exp("b1_clear", F_STATE, 5, 1);
        push_exp("b1_done", F_DONE, 1, 1);
        push_exp("b1_win_state", F_STATE, 6, 2);
        push_exp("b1_win", F_WIN, 1, 2);
        push_exp("b1_win_level", F_LEVEL, 1, 2);
        tick(2);
        drive(0, 4'b0001, 1); push_exp("win_ign_state", F_STATE, 6, 0);
                              push_exp("win_ign_cursor", F_CURSOR, 1, 0);
        drive(1, 4'b0000, 0); push_exp("win_start_state", F_STATE, 0, 0);
                              push_exp("win_start_level", F_LEVEL, 0, 0);
                              push_exp("win_start_win", F_WIN, 0, 0);
        tick(3);

        n_cmp++;
        if (done_count != 2) begin
            n_bad++;
            $display("FAIL board_done_count: got %0d, expected 2", done_count);
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_game_ctrl.md
# memory_game_ctrl

Parametrised game controller for the card-matching game. It replaces the fixed 6x6 arrow-key/compare/FSM chain with one sequential block. It navigates a cursor over a COLS x ROWS board, handles two-card selection, compares symbols, holds mismatches face-up for a programmable time, tracks matched pairs, moves and level, and flags board clear and win. It sits between the input synchroniser (pulsed keys/start/select) and the draw and seven-segment blocks.

## Interface
- COLS, 6, board columns (≥2)
- ROWS, 6, board rows (≥2); COLS*ROWS must be even
- SYM_W, 5, card symbol width
- SHOW_CYCLES, 50_000_000, mismatch display hold in clocks (≥2)
- MAX_LEVEL, 3, number of levels before win (≥1)
- Derived: N = COLS*ROWS, IDX_W = $clog2(N), PAIR_W = $clog2(N/2+1)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, already synchronised
- keys  in  4  one-cycle move pulses: [0] right, [1] left, [2] down, [3] up
- select  in  1  one-cycle pulse, already synchronised
- card_sym  in  SYM_W  symbol at card_addr, combinational, valid same cycle
- card_addr  out  IDX_W  equals cursor_idx
- cursor_idx  out  IDX_W  cursor position, row*COLS+col
- sym1, sym2  out  SYM_W  latched first/second symbols (seven-segment)
- revealed  out  N  face-up mask (includes matched)
- matched  out  N  matched mask
- pairs  out  PAIR_W  pairs found on current board
- moves  out  16  completed pair attempts, saturating at 16'hFFFF
- level  out  $clog2(MAX_LEVEL+1)  current level, from 0
- state  out  3  current FSM state (game_pkg encoding)
- board_done  out  1  one-cycle pulse on board clear
- win  out  1  high in WIN state

## Operation
- States: IDLE, PICK1, PICK2, COMPARE, SHOW, CLEAR, WIN.
- IDLE:
  - start → PICK1.
  - Clears revealed, matched, pairs, moves, sym1, sym2, and sets cursor to 0.
- PICK1:
  - keys move the cursor.
  - select on an unmatched card latches first_idx and sym1 ← card_sym, sets revealed[cursor], then → PICK2.
  - select on a matched card is ignored.
- PICK2:
  - keys move the cursor.
  - select on an unmatched card with cursor ≠ first_idx latches sym2, sets revealed[cursor], increments moves (saturating), then → COMPARE.
  - Any other select is ignored.
- COMPARE (1 cycle):
  - sym1 == sym2: sets matched bits for both cards and increments pairs. Then → CLEAR if the new pairs == N/2, else → PICK1.
  - Otherwise → SHOW, with the timer loaded to SHOW_CYCLES−1.
- SHOW:
  - Timer decrements each cycle.
  - At 0, clears revealed for both cards → PICK1.
- CLEAR (1 cycle):
  - Asserts board_done.
  - If level == MAX_LEVEL−1 → WIN.
  - Else level+1 → IDLE. The external board loader refreshes symbols; start is required to begin the next board.
- WIN:
  - win = 1.
  - start clears level to 0 → IDLE.
- Cursor rules:
  - Right/left wrap within the row; down/up wrap within the column.
  - Simultaneous key bits: priority up > down > left > right, one step per pulse.
- Ignored inputs:
  - keys and select are ignored in IDLE, COMPARE, SHOW, CLEAR and WIN.
  - start is ignored outside IDLE and WIN.
- Reset: all outputs return to their reset values at any point, including mid-SHOW. State IDLE, level 0, all masks/counters/symbols 0, pulses low.

## Timing
- All outputs are registered. A key pulse at edge t moves cursor_idx at t+1.
- Select in PICK2 at t:
  - state = COMPARE, revealed updated at t+1.
  - matched/pairs updated and the next state entered at t+2.
- Mismatch: SHOW is entered at t+2. The revealed bits clear SHOW_CYCLES cycles later, in the same cycle state returns to PICK1.
- board_done is high exactly one cycle, the cycle state == CLEAR.
- No handshake on card_sym. The symbol source must stay stable while the state is not IDLE.

## Structure
- game_pkg holds:
  - the state enum (3-bit: IDLE=0, PICK1=1, PICK2=2, COMPARE=3, SHOW=4, CLEAR=5, WIN=6);
  - the key bit-position constants;
  - the saturating increment function.
- Sub-module cursor_nav (parameters COLS, ROWS) holds the row/col registers, applies priority and wrap, and outputs the linear index. Its moves are gated by an enable driven in PICK1/PICK2.

## Test plan
All scenarios use COLS=2, ROWS=2, SYM_W=5, SHOW_CYCLES=4, MAX_LEVEL=2, board symbols {3,7,3,7}.
- Reset mid-SHOW → next cycle state=IDLE, revealed=0, matched=0, level=0, pairs=0.
- start; select idx0; right; select idx1 → COMPARE, moves=1. Then SHOW for 4 cycles, revealed returns to 0, state=PICK1.
- start; select 0; down; select 2 → matched=4'b0101, pairs=1, state=PICK1. A select on idx0 or idx2 is then ignored.
- Cursor wrap: right twice from 0 → idx 0. up from 0 → idx 2. keys=4'b1001 at idx0 → idx2 (up wins).
- Select same card twice in PICK2 → ignored, state stays PICK2, moves unchanged.
- Clear a board twice → board_done pulses once per board, level 0→1, then WIN with win=1. start in WIN → IDLE, level=0.
